// File: rtl/usb_data_rx_crc.sv
// usb_data_rx_crc
//   Receive-side byte stage for USB DATA0/DATA1 payloads (PID already
//   stripped). Runs the reflected USB CRC-16 over every byte, CRC bytes
//   included, and checks the 0xB001 residual at end of packet. It also
//   reports the payload length and length errors. The first 8 bytes are
//   captured as the 64-bit SETUP word.
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   rx_valid      : rx_data holds a byte this cycle
//   rx_data[7:0]  : byte in USB wire order
//   rx_sop/rx_eop : first/last byte of a packet (qualified by rx_valid)
//   busy          : packet in progress
//   done          : one-cycle result strobe
//   crc_ok        : residual matched and length legal (held until next done)
//   len_err       : fewer than 2 or more than MAX_BYTES bytes (held)
//   pkt_len[10:0] : payload bytes excluding CRC (held)
//   setup_data    : first 8 bytes, byte 0 in [7:0]
//   setup_valid   : strobe with done for a good 8-byte payload
module usb_data_rx_crc #(
   parameter int MAX_BYTES = 1026
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_sop,
   input  logic        rx_eop,
   output logic        busy,
   output logic        done,
   output logic        crc_ok,
   output logic        len_err,
   output logic [10:0] pkt_len,
   output logic [63:0] setup_data,
   output logic        setup_valid
);

   localparam logic [10:0] MAX_LEN   = 11'(MAX_BYTES);
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   localparam logic [15:0] CRC_RESID = 16'hB001;

   typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

   state_t      state, state_nx;
   logic [15:0] crc, crc_nx;
   logic [10:0] cnt, cnt_nx;
   logic [10:0] byte_idx;
   logic [10:0] pkt_len_nx;
   logic        start, take, last;
   logic        len_err_nx, crc_ok_nx;

   // Eight LSB-first bit steps of the reflected polynomial, one byte per clock.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ 16'hA001;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      done       = 1'b0;
      // An SOP byte starts a packet in any state: from RECV it aborts the
      // current one, and from REPORT it overlaps the result cycle.
      start      = rx_valid & rx_sop;
      take       = start | (rx_valid & (state == RECV));
      last       = take & rx_eop;
      crc_nx     = crc16_byte(start ? CRC_INIT : crc, rx_data);
      cnt_nx     = start ? 11'd1 : ((cnt == 11'h7FF) ? cnt : cnt + 11'd1);
      len_err_nx = (cnt_nx < 11'd2) || (cnt_nx > MAX_LEN);
      crc_ok_nx  = (crc_nx == CRC_RESID) && !len_err_nx;
      pkt_len_nx = (cnt_nx >= 11'd2) ? cnt_nx - 11'd2 : 11'd0;
      byte_idx   = start ? 11'd0 : cnt;

      case (state)
         IDLE: begin
            if (start) state_nx = rx_eop ? REPORT : RECV;
         end
         RECV: begin
            busy = 1'b1;
            if (take && rx_eop) state_nx = REPORT;
            else if (start)     state_nx = RECV;
         end
         REPORT: begin
            done = 1'b1;
            if (start) state_nx = rx_eop ? REPORT : RECV;
            else       state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Results are latched on the EOP byte, so they are already valid during
   // the REPORT (done) cycle and stay put until the next EOP.
   always_ff @(posedge clk) begin
      if (reset) begin
         crc         <= CRC_INIT;
         cnt         <= 11'd0;
         crc_ok      <= 1'b0;
         len_err     <= 1'b0;
         pkt_len     <= 11'd0;
         setup_data  <= 64'd0;
         setup_valid <= 1'b0;
      end else begin
         setup_valid <= 1'b0;
         if (take) begin
            crc <= crc_nx;
            cnt <= cnt_nx;
            if (byte_idx < 11'd8)
               setup_data[byte_idx[2:0]*8 +: 8] <= rx_data;
         end
         if (last) begin
            crc_ok      <= crc_ok_nx;
            len_err     <= len_err_nx;
            pkt_len     <= pkt_len_nx;
            setup_valid <= crc_ok_nx && (pkt_len_nx == 11'd8);
         end
      end
   end

endmodule

// File: tb/tb_usb_data_rx_crc.sv
// Directed bench for usb_data_rx_crc. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_usb_data_rx_crc;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_sop;
   logic        rx_eop;
   logic        busy, done, crc_ok, len_err, setup_valid;
   logic [10:0] pkt_len;
   logic [63:0] setup_data;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int d0;

   logic [7:0] q_zero[$];
   logic [7:0] q_good[$];
   logic [7:0] q_bad[$];
   logic [7:0] q_setup[$];
   logic [7:0] q_one[$];
   logic [7:0] q_long[$];

   usb_data_rx_crc #(.MAX_BYTES(1026)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_sop(rx_sop), .rx_eop(rx_eop), .busy(busy), .done(done),
      .crc_ok(crc_ok), .len_err(len_err), .pkt_len(pkt_len),
      .setup_data(setup_data), .setup_valid(setup_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e);
      @(negedge clk);
      rx_valid = v; rx_data = d; rx_sop = s; rx_eop = e;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Returns at the falling edge where the EOP byte has just been driven.
   task automatic send_pkt(input logic [7:0] q[$], input bit gaps);
      for (int i = 0; i < q.size(); i++) begin
         drive(1'b1, q[i], i == 0, i == q.size() - 1);
         if (gaps && i != q.size() - 1) drive(1'b0, 8'hEE, 1'b0, 1'b0);
      end
   endtask

   initial begin
      q_zero  = '{8'h00, 8'h00};
      q_good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
      q_bad   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB5};
      q_setup = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      q_one   = '{8'h5A};
      for (int i = 0; i < 1030; i++) q_long.push_back(i[7:0]);

      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sop = 1'b0; rx_eop = 1'b0;
      idle(3);
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_crc_ok", crc_ok, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_pkt_len", pkt_len, 0);
      chk("rst_setup_data", setup_data, 0);
      chk("rst_setup_valid", setup_valid, 0);

      // zero-length DATA packet
      send_pkt(q_zero, 0);
      chk("zl_busy_mid", busy, 1);
      chk("zl_done_early", done, 0);
      idle(1);
      chk("zl_done", done, 1);
      chk("zl_busy_done", busy, 0);
      chk("zl_crc_ok", crc_ok, 1);
      chk("zl_pkt_len", pkt_len, 0);
      chk("zl_len_err", len_err, 0);
      chk("zl_setup_valid", setup_valid, 0);
      idle(1);
      chk("zl_done_pulse", done, 0);
      chk("zl_crc_ok_held", crc_ok, 1);

      // "123456789" + good CRC
      send_pkt(q_good, 0);
      idle(1);
      chk("good_done", done, 1);
      chk("good_crc_ok", crc_ok, 1);
      chk("good_pkt_len", pkt_len, 9);
      chk("good_len_err", len_err, 0);

      // corrupted last CRC byte
      send_pkt(q_bad, 0);
      idle(1);
      chk("bad_done", done, 1);
      chk("bad_crc_ok", crc_ok, 0);
      chk("bad_pkt_len", pkt_len, 9);

      // SETUP packet
      send_pkt(q_setup, 0);
      idle(1);
      chk("setup_done", done, 1);
      chk("setup_valid", setup_valid, 1);
      chk("setup_crc_ok", crc_ok, 1);
      chk("setup_pkt_len", pkt_len, 8);
      chk("setup_data", setup_data, 64'h0040000001000680);
      idle(1);
      chk("setup_valid_pulse", setup_valid, 0);

      // single byte sop+eop
      send_pkt(q_one, 0);
      idle(1);
      chk("one_done", done, 1);
      chk("one_len_err", len_err, 1);
      chk("one_crc_ok", crc_ok, 0);
      chk("one_pkt_len", pkt_len, 0);

      // oversize packet
      send_pkt(q_long, 0);
      idle(1);
      chk("long_done", done, 1);
      chk("long_len_err", len_err, 1);
      chk("long_crc_ok", crc_ok, 0);
      chk("long_pkt_len", pkt_len, 1028);

      // abort: 5 bytes then SOP restart with the good packet
      idle(2);
      d0 = done_cnt;
      drive(1'b1, 8'h11, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h22, 1'b0, 1'b0);
      send_pkt(q_good, 0);
      idle(1);
      chk("abort_done", done, 1);
      chk("abort_crc_ok", crc_ok, 1);
      chk("abort_pkt_len", pkt_len, 9);
      idle(2);
      chk("abort_done_count", done_cnt - d0, 1);

      // reset on byte 4
      d0 = done_cnt;
      drive(1'b1, 8'h80, 1'b1, 1'b0);
      drive(1'b1, 8'h06, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      chk("rr_busy", busy, 0);
      chk("rr_done", done, 0);
      chk("rr_crc_ok", crc_ok, 0);
      chk("rr_pkt_len", pkt_len, 0);
      chk("rr_setup_data", setup_data, 0);
      idle(3);
      chk("rr_no_done", done_cnt - d0, 0);

      // stray idle bytes, then gaps inside a packet
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      drive(1'b1, 8'h55, 1'b0, 1'b1);
      chk("stray_busy", busy, 0);
      send_pkt(q_good, 1);
      idle(1);
      chk("gap_done", done, 1);
      chk("gap_crc_ok", crc_ok, 1);
      chk("gap_pkt_len", pkt_len, 9);

      // back-to-back: next SOP lands in the done cycle
      send_pkt(q_bad, 0);
      drive(1'b1, q_setup[0], 1'b1, 1'b0);
      chk("b2b_done1", done, 1);
      chk("b2b_crc_ok1", crc_ok, 0);
      for (int i = 1; i < q_setup.size(); i++)
         drive(1'b1, q_setup[i], 1'b0, i == q_setup.size() - 1);
      idle(1);
      chk("b2b_done2", done, 1);
      chk("b2b_crc_ok2", crc_ok, 1);
      chk("b2b_setup_valid", setup_valid, 1);
      chk("b2b_setup_data", setup_data, 64'h0040000001000680);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
